// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver:
// scan phase enum, active-high g..a glyph table and output polarity helper.
package sevenseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_t;

  // Index k holds the glyph for hex value k, bit 6 = g ... bit 0 = a.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_pol(input logic [6:0] seg_hi, input logic active_low);
    if (active_low) begin
      return ~seg_hi;
    end else begin
      return seg_hi;
    end
  endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational hex to seven-segment decode (active-high g..a) with blanking.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup, forced dark while blanked
  always_comb begin
    seg = 7'h00;
    if (blank) begin
      seg = 7'h00;
    end else begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/sevenseg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with per-frame snapshot and sum readout.
// Optional leading-zero suppression: define SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_mux_n
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 24000,
  parameter int BLANK_CYCLES   = 240,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int EN_ACTIVE_LOW  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [4*NUM_DIGITS-1:0]           digits_in,
  input  logic [NUM_DIGITS-1:0]             dp_in,
  output logic [6:0]                        seg,
  output logic                              dp,
  output logic [NUM_DIGITS-1:0]             enable,
  output logic [4+$clog2(NUM_DIGITS)-1:0]   led_sum,
  output logic                              frame_start
);

  localparam int   CNT_W   = $clog2(REFRESH_DIV);
  localparam int   IDX_W   = $clog2(NUM_DIGITS);
  localparam int   SUM_W   = 4 + IDX_W;
  localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic EN_LOW  = (EN_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  phase_t                  phase_r;
  phase_t                  phase_nx_s;
  logic [4*NUM_DIGITS-1:0] snap_r;
  logic [NUM_DIGITS-1:0]   snap_dp_r;
  logic [SUM_W-1:0]        sum_s;
  logic [SUM_W-1:0]        led_sum_r;
  logic [NUM_DIGITS-1:0]   show_mask_s;
  logic [3:0]              digit_s;
  logic                    dp_sel_s;
  logic                    on_s;
  logic [6:0]              dec_seg_s;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   enable_r;
  logic                    last_s;
  logic                    snap_en_s;

  assign last_s    = (cnt_r == CNT_W'(REFRESH_DIV - 1));
  assign snap_en_s = (cnt_r == {CNT_W{1'b0}}) && (idx_r == {IDX_W{1'b0}});

  // Phase transitions within a slot
  always_comb begin
    phase_nx_s = phase_r;
    case (phase_r)
      BLANK: begin
        if (cnt_r == CNT_W'(BLANK_CYCLES - 1)) phase_nx_s = SHOW;
        else                                   phase_nx_s = BLANK;
      end
      SHOW: begin
        if (last_s) phase_nx_s = BLANK;
        else        phase_nx_s = SHOW;
      end
      default: phase_nx_s = BLANK;
    endcase
  end

  // Slot counter, digit index and phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      phase_r <= BLANK;
    end else begin
      phase_r <= phase_nx_s;
      if (last_s) begin
        cnt_r <= {CNT_W{1'b0}};
        if (idx_r == IDX_W'(NUM_DIGITS - 1)) idx_r <= {IDX_W{1'b0}};
        else                                 idx_r <= idx_r + IDX_W'(1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Frame snapshot and registered sum of the snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_r    <= {(4*NUM_DIGITS){1'b0}};
      snap_dp_r <= {NUM_DIGITS{1'b0}};
      led_sum_r <= {SUM_W{1'b0}};
    end else begin
      if (snap_en_s) begin
        snap_r    <= digits_in;
        snap_dp_r <= dp_in;
      end
      led_sum_r <= sum_s;
    end
  end

  // Adder tree over the snapshot; width never overflows for NUM_DIGITS x 15
  always_comb begin
    sum_s = {SUM_W{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sum_s = sum_s + SUM_W'(snap_r[4*k +: 4]);
    end
  end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // Digits above the highest nonzero one stay dark; digit 0 is always lit
  always_comb begin
    logic any_s;
    any_s       = 1'b0;
    show_mask_s = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      any_s          = any_s | (snap_r[4*k +: 4] != 4'h0);
      show_mask_s[k] = any_s | (k == 0);
    end
  end
`else
  assign show_mask_s = {NUM_DIGITS{1'b1}};
`endif

  // Select the scanned digit; outputs follow the next phase so they align with phase_r
  always_comb begin
    digit_s  = snap_r[4*int'(idx_r) +: 4];
    dp_sel_s = snap_dp_r[idx_r];
    on_s     = (phase_nx_s == SHOW) && show_mask_s[idx_r];
  end

  sevenseg_decoder u_decoder (
    .digit (digit_s),
    .blank (!on_s),
    .seg   (dec_seg_s)
  );

  // Registered display outputs with polarity applied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_r    <= seg_pol(7'h00, SEG_LOW);
      dp_r     <= SEG_LOW;
      enable_r <= {NUM_DIGITS{EN_LOW}};
    end else begin
      seg_r    <= seg_pol(dec_seg_s, SEG_LOW);
      dp_r     <= (on_s & dp_sel_s) ^ SEG_LOW;
      enable_r <= (on_s ? (NUM_DIGITS'(1) << idx_r) : {NUM_DIGITS{1'b0}}) ^ {NUM_DIGITS{EN_LOW}};
    end
  end

  assign seg         = seg_r;
  assign dp          = dp_r;
  assign enable      = enable_r;
  assign led_sum     = led_sum_r;
  assign frame_start = snap_en_s & ~reset;

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// Directed bench for sevenseg_mux_n: a 2-digit and a 4-digit instance, slot 8, blank 2, active-low.
module tb_sevenseg_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, rst4;
  logic [7:0] dig2;
  logic [1:0] dpi2, en2;
  logic [6:0] seg2;
  logic       dp2, fs2;
  logic [4:0] sum2;

  logic [15:0] dig4;
  logic [3:0]  dpi4, en4;
  logic [6:0]  seg4;
  logic        dp4, fs4;
  logic [5:0]  sum4;

  int total = 0;
  int bad   = 0;

  sevenseg_mux_n #(.NUM_DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                   .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .reset(rst2), .digits_in(dig2), .dp_in(dpi2), .seg(seg2),
    .dp(dp2), .enable(en2), .led_sum(sum2), .frame_start(fs2));

  sevenseg_mux_n #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                   .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) dut4 (
    .clk(clk), .reset(rst4), .digits_in(dig4), .dp_in(dpi4), .seg(seg4),
    .dp(dp4), .enable(en4), .led_sum(sum4), .frame_start(fs4));

  typedef struct {
    logic [7:0] dig;
    logic [1:0] dpv;
    logic [4:0] sum;
    logic [6:0] g0;
    logic [6:0] g1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] lz_mask(input logic [15:0] d, input int n);
    logic [3:0] m;
    m = 4'hF;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    begin
      logic any;
      any = 1'b0;
      m   = 4'h0;
      for (int k = 3; k >= 0; k--) begin
        if (k < n) begin
          any  = any | (d[4*k +: 4] != 4'h0);
          m[k] = any | (k == 0);
        end
      end
    end
`endif
    return m;
  endfunction

  // Expected display state for cycle c after reset release (c=0 is the first cycle).
  task automatic check_cycle(input int n, input int c, input logic [3:0][6:0] glyph,
                             input logic [3:0] shown, input logic [3:0] dpv);
    int slot, cnt;
    logic [3:0] exp_en, act_en;
    logic [6:0] exp_seg, act_seg;
    logic exp_dp, act_dp, act_fs;
    slot = (c / 8) % n;
    cnt  = c % 8;
    exp_en = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    if (cnt >= 2 && shown[slot]) begin
      exp_en[slot] = 1'b0;
      exp_seg      = glyph[slot];
      exp_dp       = ~dpv[slot];
    end
    if (n == 2) begin
      act_en = {2'b11, en2}; act_seg = seg2; act_dp = dp2; act_fs = fs2;
    end else begin
      act_en = en4; act_seg = seg4; act_dp = dp4; act_fs = fs4;
    end
    chk("enable", c, 32'(act_en), 32'(exp_en));
    chk("seg", c, 32'(act_seg), 32'(exp_seg));
    chk("dp", c, 32'(act_dp), 32'(exp_dp));
    chk("frame_start", c, 32'(act_fs), 32'((c % (8*n)) == 0));
  endtask

  task automatic check_sum(input int n, input int c, input logic [5:0] exp);
    if (n == 2) chk("led_sum", c, 32'(sum2), 32'(exp));
    else        chk("led_sum", c, 32'(sum4), 32'(exp));
  endtask

  // Release reset at a falling edge and check cycle 0.
  task automatic start(input int n, input logic [3:0][6:0] glyph, input logic [3:0] shown,
                       input logic [3:0] dpv);
    if (n == 2) rst2 = 1'b1; else rst4 = 1'b1;
    @(negedge clk);
    if (n == 2) rst2 = 1'b0; else rst4 = 1'b0;
    #1;
    check_cycle(n, 0, glyph, shown, dpv);
    check_sum(n, 0, 6'd0);
  endtask

  task automatic run(input int n, input int c_from, input int c_to, input logic [3:0][6:0] glyph,
                     input logic [3:0] shown, input logic [3:0] dpv, input logic [5:0] sum);
    for (int c = c_from; c <= c_to; c++) begin
      @(negedge clk);
      check_cycle(n, c, glyph, shown, dpv);
      if (c >= 2) check_sum(n, c, sum);
    end
  endtask

  initial begin
    logic [3:0][6:0] g;
    logic [3:0]      m;

    vecs[0] = '{dig: 8'hA3, dpv: 2'b00, sum: 5'd13, g0: 7'h30, g1: 7'h08};
    vecs[1] = '{dig: 8'h55, dpv: 2'b01, sum: 5'd10, g0: 7'h12, g1: 7'h12};
    vecs[2] = '{dig: 8'h0F, dpv: 2'b10, sum: 5'd15, g0: 7'h0E, g1: 7'h40};
    vecs[3] = '{dig: 8'hB8, dpv: 2'b00, sum: 5'd19, g0: 7'h00, g1: 7'h03};
    vecs[4] = '{dig: 8'hD0, dpv: 2'b11, sum: 5'd13, g0: 7'h40, g1: 7'h21};

    rst2 = 1'b1; rst4 = 1'b1;
    dig2 = 8'h00; dpi2 = 2'b00; dig4 = 16'h0000; dpi4 = 4'h0;
    #12;
    chk("rst_enable", 0, 32'(en2), 32'(2'b11));
    chk("rst_seg", 0, 32'(seg2), 32'(7'h7F));
    chk("rst_dp", 0, 32'(dp2), 32'(1'b1));
    chk("rst_sum", 0, 32'(sum2), 32'(5'd0));
    chk("rst_frame_start", 0, 32'(fs2), 32'(1'b0));

    // Table-driven full frames on the 2-digit instance
    for (int v = 0; v < 5; v++) begin
      dig2 = vecs[v].dig;
      dpi2 = vecs[v].dpv;
      g    = {7'h7F, 7'h7F, vecs[v].g1, vecs[v].g0};
      m    = lz_mask({8'h00, vecs[v].dig}, 2);
      start(2, g, m, {2'b00, vecs[v].dpv});
      run(2, 1, 16, g, m, {2'b00, vecs[v].dpv}, {1'b0, vecs[v].sum});
    end

    // Mid-frame input change is held off until the next snapshot
    dig2 = 8'hA3; dpi2 = 2'b00;
    g = {7'h7F, 7'h7F, 7'h08, 7'h30};
    start(2, g, 4'hF, 4'h0);
    run(2, 1, 9, g, 4'hF, 4'h0, 6'd13);
    dig2 = 8'h55;
    run(2, 10, 17, g, 4'hF, 4'h0, 6'd13);
    g = {7'h7F, 7'h7F, 7'h12, 7'h12};
    run(2, 18, 28, g, 4'hF, 4'h0, 6'd10);

    // Asynchronous reset in the middle of a SHOW phase of slot 1
    #2 rst2 = 1'b1;
    #1;
    chk("midrst_enable", 28, 32'(en2), 32'(2'b11));
    chk("midrst_seg", 28, 32'(seg2), 32'(7'h7F));
    chk("midrst_dp", 28, 32'(dp2), 32'(1'b1));
    chk("midrst_sum", 28, 32'(sum2), 32'(5'd0));
    start(2, g, 4'hF, 4'h0);
    run(2, 1, 10, g, 4'hF, 4'h0, 6'd10);

    // Widest sum on the 4-digit instance
    dig4 = 16'hFFFF; dpi4 = 4'b1010;
    g = {7'h0E, 7'h0E, 7'h0E, 7'h0E};
    start(4, g, 4'hF, 4'b1010);
    run(4, 1, 32, g, 4'hF, 4'b1010, 6'd60);

    // Leading zeros: shown as "0" by default, dark with suppression enabled
    dig4 = 16'h0052; dpi4 = 4'b1111;
    g = {7'h40, 7'h40, 7'h12, 7'h24};
    m = lz_mask(16'h0052, 4);
    start(4, g, m, 4'b1111);
    run(4, 1, 34, g, m, 4'b1111, 6'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
